capture_readout_fsm: RTL and testbench

- Capture-side responder to the design block's `capture_waiting`/`capture_enable` handshake.
- When armed, it raises `capture_waiting` and waits for the design to grant `capture_enable`.
- It then records `CAP_LEN` beats of a packed 128-bit AXI4S stream (8 × 12-bit samples in 16-bit lanes) into on-chip RAM.
- It then replays the record as a back-pressured AXI4S stream with `tlast`. Sits between the design's buf stream and the readout DMA.

---
 rtl/capture_readout_fsm.sv | 246 ++++++++++++++++++++++++
 tb/tb_capture_readout_fsm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_readout_fsm.sv
// -----------------------------------------------------------------------------
// capture_readout_fsm
//
// Capture-side responder for the capture_waiting / capture_enable handshake.
// When armed it raises capture_waiting, waits for the design to grant
// capture_enable, records CAP_LEN beats of a packed 128-bit AXI4S stream
// (8 x 12-bit samples in 16-bit lanes) into on-chip RAM, then replays the
// record as a back-pressured AXI4S stream with tlast.
//
// Ports:
//   aclk            stream clock, all logic on its rising edge
//   aresetn         synchronous active-low reset
//   arm_i           single-cycle capture request (honoured only in IDLE)
//   capture_waiting high while armed and awaiting the grant
//   capture_enable  grant from the design block; low pauses capture
//   cap_tdata/tvalid/tready  capture stream (tready tied high)
//   rd_tdata/tvalid/tready/tlast  replay stream
//   busy_o          high in any state other than IDLE
//   done_o          one-cycle pulse after the final replay beat is accepted
//   lane_err_o      sticky pack-format error
//
// Optional feature macro: CAPTURE_LANE_CHECK_EN
//   Defined  : a stored beat with a nonzero low nibble in any 16-bit lane
//              sets lane_err_o until the next arm or reset.
//   Undefined: lane_err_o is tied 0 and no check logic is built.
// -----------------------------------------------------------------------------
module capture_readout_fsm #(
    parameter int ADDR_BITS = 10,
    parameter int CAP_LEN   = 512
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         arm_i,
    output logic         capture_waiting,
    input  logic         capture_enable,
    input  logic [127:0] cap_tdata,
    input  logic         cap_tvalid,
    output logic         cap_tready,
    output logic [127:0] rd_tdata,
    output logic         rd_tvalid,
    input  logic         rd_tready,
    output logic         rd_tlast,
    output logic         busy_o,
    output logic         done_o,
    output logic         lane_err_o
);

    localparam int                 DEPTH     = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] WR_LAST_C = ADDR_BITS'(CAP_LEN - 1);
    localparam logic [ADDR_BITS-1:0] WR_ONE_C  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS:0]   RD_LEN_C  = (ADDR_BITS + 1)'(CAP_LEN);
    localparam logic [ADDR_BITS:0]   RD_LAST_C = (ADDR_BITS + 1)'(CAP_LEN - 1);
    localparam logic [ADDR_BITS:0]   RD_ONE_C  = (ADDR_BITS + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PRIME   = 3'd3,
        ST_REPLAY  = 3'd4
    } state_t;

    state_t               state_r;
    logic [127:0]         mem_r [0:DEPTH-1];
    logic [ADDR_BITS-1:0] wr_cnt_r;
    logic [ADDR_BITS:0]   rd_cnt_r;      // next read address; one bit wider to reach CAP_LEN
    logic [127:0]         ram_q_r;       // RAM read data, valid the cycle after issue
    logic                 ram_q_vld_r;
    logic                 ram_q_last_r;
    logic [127:0]         skid_data_r;
    logic                 skid_vld_r;
    logic                 skid_last_r;

    logic                 we_s;
    logic                 pop_s;
    logic                 issue_s;
    logic                 in_replay_s;
    logic [1:0]           held_s;
    logic [1:0]           after_pop_s;

    assign cap_tready = 1'b1;

    // Write strobe, replay handshake and read-prefetch decision.
    always_comb begin
        we_s        = (state_r == ST_CAPTURE) && capture_enable && cap_tvalid;
        in_replay_s = (state_r == ST_PRIME) || (state_r == ST_REPLAY);
        pop_s       = rd_tvalid && rd_tready;
        // Beats already owned by the replay path: output reg, skid, RAM read in flight.
        held_s      = {1'b0, rd_tvalid} + {1'b0, skid_vld_r} + {1'b0, ram_q_vld_r};
        after_pop_s = held_s - {1'b0, pop_s};
        // A new read is only issued if its data is guaranteed a slot next cycle
        // even when the consumer stalls, so nothing is ever dropped.
        issue_s     = in_replay_s && (rd_cnt_r < RD_LEN_C) && (after_pop_s <= 2'd1);
    end

    // Capture RAM: synchronous write and 1-cycle-latency read, never reset.
    always_ff @(posedge aclk) begin
        if (we_s) begin
            mem_r[wr_cnt_r] <= cap_tdata;
        end
        if (issue_s) begin
            ram_q_r <= mem_r[rd_cnt_r[ADDR_BITS-1:0]];
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r         <= ST_IDLE;
            wr_cnt_r        <= '0;
            capture_waiting <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (arm_i) begin
                        state_r         <= ST_WAIT;
                        capture_waiting <= 1'b1;
                        busy_o          <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // The beat presented in the grant cycle is deliberately not stored.
                    if (capture_enable) begin
                        state_r         <= ST_CAPTURE;
                        capture_waiting <= 1'b0;
                        wr_cnt_r        <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (we_s) begin
                        if (wr_cnt_r == WR_LAST_C) begin
                            wr_cnt_r <= '0;
                            state_r  <= ST_PRIME;
                        end else begin
                            wr_cnt_r <= wr_cnt_r + WR_ONE_C;
                        end
                    end
                end
                ST_PRIME: begin
                    // Read of address 0 is issued this cycle by the prefetch logic.
                    state_r <= ST_REPLAY;
                end
                ST_REPLAY: begin
                    if (pop_s && rd_tlast) begin
                        state_r <= ST_IDLE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    wr_cnt_r        <= '0;
                    capture_waiting <= 1'b0;
                    busy_o          <= 1'b0;
                end
            endcase
        end
    end

    // Replay pipeline: read prefetch -> skid -> output register, in beat order.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_cnt_r     <= '0;
            ram_q_vld_r  <= 1'b0;
            ram_q_last_r <= 1'b0;
            skid_data_r  <= '0;
            skid_vld_r   <= 1'b0;
            skid_last_r  <= 1'b0;
            rd_tdata     <= '0;
            rd_tvalid    <= 1'b0;
            rd_tlast     <= 1'b0;
        end else begin
            ram_q_vld_r  <= issue_s;
            ram_q_last_r <= issue_s && (rd_cnt_r == RD_LAST_C);
            if (issue_s) begin
                rd_cnt_r <= rd_cnt_r + RD_ONE_C;
            end else if (!in_replay_s) begin
                rd_cnt_r <= '0;
            end

            if (pop_s) begin
                // Head consumed: advance the oldest remaining beat into the output.
                if (skid_vld_r) begin
                    rd_tdata  <= skid_data_r;
                    rd_tlast  <= skid_last_r;
                    rd_tvalid <= 1'b1;
                    if (ram_q_vld_r) begin
                        skid_data_r <= ram_q_r;
                        skid_last_r <= ram_q_last_r;
                        skid_vld_r  <= 1'b1;
                    end else begin
                        skid_vld_r  <= 1'b0;
                        skid_last_r <= 1'b0;
                    end
                end else if (ram_q_vld_r) begin
                    rd_tdata  <= ram_q_r;
                    rd_tlast  <= ram_q_last_r;
                    rd_tvalid <= 1'b1;
                end else begin
                    rd_tvalid <= 1'b0;
                    rd_tlast  <= 1'b0;
                end
            end else if (!rd_tvalid) begin
                if (ram_q_vld_r) begin
                    rd_tdata  <= ram_q_r;
                    rd_tlast  <= ram_q_last_r;
                    rd_tvalid <= 1'b1;
                end
            end else if (ram_q_vld_r) begin
                // Output stalled: park the arriving beat (skid is known empty here).
                skid_data_r <= ram_q_r;
                skid_last_r <= ram_q_last_r;
                skid_vld_r  <= 1'b1;
            end
        end
    end

`ifdef CAPTURE_LANE_CHECK_EN
    // True when any 16-bit lane carries a nonzero low nibble.
    function automatic logic lane_nibble_err(input logic [127:0] beat);
        logic err;
        err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            err = err | (beat[16*i +: 4] != 4'h0);
        end
        return err;
    endfunction

    // Sticky pack-format flag: cleared on arm, set by any bad stored beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            lane_err_o <= 1'b0;
        end else if ((state_r == ST_IDLE) && arm_i) begin
            lane_err_o <= 1'b0;
        end else if (we_s && lane_nibble_err(cap_tdata)) begin
            lane_err_o <= 1'b1;
        end
    end
`else
    assign lane_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_capture_readout_fsm.sv
module tb_capture_readout_fsm;

    localparam int ADDR_BITS = 10;
    localparam int CAP_LEN   = 512;
    localparam int BUDGET    = 20000;
    localparam int P_IDLE = 0, P_WAIT = 1, P_CAP = 2, P_REPLAY = 3;
`ifdef CAPTURE_LANE_CHECK_EN
    localparam logic LANE_EXP = 1'b1;
`else
    localparam logic LANE_EXP = 1'b0;
`endif

    logic         aclk;
    logic         rstn, arm, en, vld, rdy;
    logic [127:0] data;
    logic         capture_waiting, cap_tready, rd_tvalid, rd_tlast;
    logic         busy_o, done_o, lane_err_o;
    logic [127:0] rd_tdata;

    capture_readout_fsm #(.ADDR_BITS(ADDR_BITS), .CAP_LEN(CAP_LEN)) dut (
        .aclk(aclk), .aresetn(rstn), .arm_i(arm),
        .capture_waiting(capture_waiting), .capture_enable(en),
        .cap_tdata(data), .cap_tvalid(vld), .cap_tready(cap_tready),
        .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tready(rdy),
        .rd_tlast(rd_tlast), .busy_o(busy_o), .done_o(done_o),
        .lane_err_o(lane_err_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Behavioural model state
    int           phase, nstored, acc, delay;
    logic         exp_valid, exp_done, exp_lane, just_reset;
    logic [127:0] exp_mem [0:CAP_LEN-1];

    int n_cmp, n_err;
    int wait_seen, done_seen, last_idx, lit_acc;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] pat(input int n);
        logic [127:0] p;
        logic [11:0]  v;
        v = n[11:0];
        for (int i = 0; i < 8; i++) p[16*i +: 16] = {v, 4'h0};
        return p;
    endfunction

    function automatic logic lane_bad(input logic [127:0] d);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 8; i++) if (d[16*i +: 4] != 4'h0) b = 1'b1;
        return b;
    endfunction

    // Advance the model across the coming edge using the inputs now applied.
    task automatic model_step();
        if (!rstn) begin
            phase = P_IDLE; nstored = 0; acc = 0; delay = 0;
            exp_valid = 1'b0; exp_done = 1'b0; exp_lane = 1'b0; just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            exp_done   = 1'b0;
            case (phase)
                P_IDLE: if (arm) begin phase = P_WAIT; exp_lane = 1'b0; end
                P_WAIT: if (en) begin phase = P_CAP; nstored = 0; end
                P_CAP: begin
                    if (en && vld) begin
                        exp_mem[nstored] = data;
`ifdef CAPTURE_LANE_CHECK_EN
                        if (lane_bad(data)) exp_lane = 1'b1;
`endif
                        nstored++;
                        if (nstored == CAP_LEN) begin
                            phase = P_REPLAY; acc = 0; delay = 1; exp_valid = 1'b0;
                        end
                    end
                end
                P_REPLAY: begin
                    if (exp_valid) begin
                        if (rdy) begin
                            acc++;
                            if (acc == CAP_LEN) begin
                                exp_done = 1'b1; exp_valid = 1'b0; phase = P_IDLE;
                            end
                        end
                    end else if (delay == 0) begin
                        exp_valid = 1'b1;
                    end else begin
                        delay--;
                    end
                end
                default: phase = P_IDLE;
            endcase
        end
    endtask

    // One clock: model, edge, then compare every output against the model.
    task automatic tick();
        model_step();
        @(posedge aclk);
        #1;
        check("capture_waiting", capture_waiting, phase == P_WAIT);
        check("busy_o", busy_o, phase != P_IDLE);
        check("rd_tvalid", rd_tvalid, exp_valid);
        check("rd_tlast", rd_tlast, exp_valid && (acc == CAP_LEN - 1));
        check("done_o", done_o, exp_done);
        check("lane_err_o", lane_err_o, exp_lane);
        check("cap_tready", cap_tready, 1'b1);
        if (exp_valid) check("rd_tdata", rd_tdata, exp_mem[acc]);
        else if (just_reset) check("rd_tdata_reset", rd_tdata, 128'h0);
        if (capture_waiting === 1'b1) wait_seen++;
        if (done_o === 1'b1) done_seen++;
    endtask

    function automatic logic [127:0] rnd_beat();
        return {$urandom(), $urandom(), $urandom(), $urandom()} & {8{16'hFFF0}};
    endfunction

    task automatic run_one(input int gap, input int pause, input int bp, input int noise,
                           input int rst_at, input int bad, input int lit);
        int cyc, wait_ticks, cap_ticks;
        wait_seen = 0; done_seen = 0; last_idx = -1; lit_acc = 0;
        wait_ticks = 0; cap_ticks = 0; cyc = 0;
        rstn = 1'b1; vld = 1'b0; rdy = 1'b1; arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en = (noise != 0);
            data = rnd_beat();
            tick();
        end
        arm = 1'b1; en = 1'b0;
        tick();
        while (phase != P_IDLE && cyc < BUDGET) begin
            cyc++;
            arm  = (noise != 0) && ($urandom_range(0, 9) == 0);
            rstn = 1'b1; en = 1'b0; vld = 1'b0;
            data = rnd_beat();
            rdy  = (bp != 0) ? ($urandom_range(0, 99) < 30) : 1'b1;
            case (phase)
                P_WAIT: begin
                    en = (wait_ticks == 4);
                    vld = 1'b1;
                    wait_ticks++;
                end
                P_CAP: begin
                    en  = !((pause != 0) && cap_ticks >= 200 && cap_ticks < 210);
                    vld = (gap != 0) ? ((cap_ticks % 2) == 0) : 1'b1;
                    if (lit != 0) data = pat(nstored);
                    if ((bad != 0) && nstored == 100) data[16*3 +: 4] = 4'h5;
                    if ((rst_at != 0) && nstored == rst_at) rstn = 1'b0;
                    cap_ticks++;
                end
                P_REPLAY: begin
                    if ((noise != 0) && exp_valid && rdy && acc == CAP_LEN - 1) arm = 1'b1;
                    if ((lit != 0) && exp_valid && rdy) begin
                        check("lit_beat", rd_tdata, pat(acc));
                        if (rd_tlast === 1'b1) last_idx = acc;
                        lit_acc++;
                    end
                end
                default: ;
            endcase
            tick();
        end
        if (cyc >= BUDGET) begin
            n_cmp++; n_err++;
            $display("FAIL run_timeout: got %0d cycles, required under %0d", cyc, BUDGET);
        end
        arm = 1'b0; rstn = 1'b1; en = 1'b0; vld = 1'b0;
        tick();
        if (lit != 0) begin
            check("lit_waiting_cycles", wait_seen, 5);
            check("lit_beats", lit_acc, CAP_LEN);
            check("lit_last_idx", last_idx, CAP_LEN - 1);
            check("lit_done_count", done_seen, 1);
            check("lit_busy_after", busy_o, 1'b0);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rstn = 1'b0; arm = 1'b0; en = 1'b0; vld = 1'b0; rdy = 1'b1; data = '0;
        for (int i = 0; i < 3; i++) tick();
        check("reset_busy", busy_o, 1'b0);
        check("reset_tdata", rd_tdata, 128'h0);

        run_one(0, 0, 0, 0, 0, 0, 1);   // basic capture and replay, literal pins
        run_one(1, 1, 0, 0, 0, 0, 0);   // gapped source and paused grant
        run_one(0, 0, 1, 0, 0, 0, 0);   // back-pressure
        run_one(1, 0, 1, 1, 0, 0, 0);   // ignored arm / grant requests
        run_one(0, 0, 0, 0, 300, 0, 0); // reset at beat 300
        check("rst_done_count", done_seen, 0);
        run_one(0, 1, 1, 0, 0, 0, 0);   // fresh capture after reset
        run_one(0, 0, 0, 0, 0, 1, 0);   // lane nibble error on beat 100
        check("lane_after_replay", lane_err_o, LANE_EXP);
        run_one(0, 0, 0, 0, 0, 0, 0);   // next arm clears the flag
        check("lane_cleared", lane_err_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
